// File: rtl/imem_arbiter_pkg.sv
// Shared constants and types for the instruction-memory arbiter.
// Holds port-count bounds, the round-robin index width and the FSM encoding.
package imem_arbiter_pkg;

    localparam int NUM_PORTS_MIN = 2;
    localparam int NUM_PORTS_MAX = 4;
    localparam int RR_IDX_W      = $clog2(NUM_PORTS_MAX);

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } arb_state_t;

endpackage

// File: rtl/imem_arbiter_rr_picker.sv
// Combinational round-robin select: scans eligible bits starting at ptr,
// wrapping at NUM_PORTS-1, and returns a one-hot grant plus its index.
module rr_picker
    import imem_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = 2
) (
    input  logic [NUM_PORTS-1:0] eligible,
    input  logic [RR_IDX_W-1:0]  ptr,
    output logic [NUM_PORTS-1:0] grant,
    output logic [RR_IDX_W-1:0]  index,
    output logic                 valid
);

    int p;

    always_comb begin
        grant = '0;
        index = '0;
        valid = 1'b0;
        p     = 0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            p = int'(ptr) + k;
            if (p >= NUM_PORTS) begin
                p = p - NUM_PORTS;
            end
            if (!valid && eligible[p]) begin
                valid    = 1'b1;
                grant[p] = 1'b1;
                index    = RR_IDX_W'(p);
            end
        end
    end

endmodule

// File: rtl/imem_arbiter.sv
// Round-robin arbiter sharing one combinational imem read port among cores.
// Grants drive mem_addr in-cycle; the fetched word returns one cycle later.
module imem_arbiter
    import imem_arbiter_pkg::*;
#(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS-1:0]            req,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_PORTS-1:0]            rvalid,
    output logic [31:0]                     rdata,
    output logic [ADDR_WIDTH-1:0]           mem_addr,
    input  logic [31:0]                     mem_data
);

    arb_state_t                state_reg, state_next;
    logic [NUM_PORTS-1:0]      rvalid_reg;
    logic [31:0]               rdata_reg;
    logic [ADDR_WIDTH-1:0]     mem_addr_reg;
    logic [RR_IDX_W-1:0]       ptr_reg, ptr_next;

    logic [ADDR_WIDTH-1:0]     port_addr [NUM_PORTS];
    logic [NUM_PORTS-1:0]      eligible;
    logic [NUM_PORTS-1:0]      grant;
    logic [RR_IDX_W-1:0]       grant_index;
    logic                      grant_valid;
    logic [ADDR_WIDTH-1:0]     sel_addr;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_addr
            assign port_addr[gi] = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
        end
    endgenerate

    // rvalid_reg doubles as the last-grant mask so a held req cannot win twice in a row.
    // Reset also blocks arbitration so mem_addr reads as zero while rst is high.
    assign eligible = rst ? '0 : (req & ~rvalid_reg);

    rr_picker #(
        .NUM_PORTS (NUM_PORTS)
    ) u_picker (
        .eligible (eligible),
        .ptr      (ptr_reg),
        .grant    (grant),
        .index    (grant_index),
        .valid    (grant_valid)
    );

    always_comb begin
        sel_addr = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant[i]) begin
                sel_addr = sel_addr | port_addr[i];
            end
        end
    end

    assign mem_addr = grant_valid ? sel_addr : mem_addr_reg;

    always_comb begin
        ptr_next   = ptr_reg;
        state_next = IDLE;
        if (grant_valid) begin
            state_next = RESP;
            ptr_next   = (grant_index == RR_IDX_W'(NUM_PORTS - 1)) ? '0
                                                                   : grant_index + RR_IDX_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            rvalid_reg   <= '0;
            rdata_reg    <= '0;
            mem_addr_reg <= '0;
            ptr_reg      <= '0;
        end else begin
            state_reg  <= state_next;
            rvalid_reg <= grant;
            ptr_reg    <= ptr_next;
            if (grant_valid) begin
                rdata_reg    <= mem_data;
                mem_addr_reg <= sel_addr;
            end
        end
    end

    assign rvalid = (state_reg == RESP) ? rvalid_reg : '0;
    assign rdata  = rdata_reg;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter: vector table on a 2-port instance,
// hand sequences for reset-in-response and a 4-port fairness run.
module tb_imem_arbiter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [1:0]  req;
    logic [63:0] req_addr;
    logic [1:0]  rvalid;
    logic [31:0] rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;

    logic [3:0]  req4;
    logic [63:0] req_addr4;
    logic [3:0]  rvalid4;
    logic [31:0] rdata4;
    logic [15:0] mem_addr4;
    logic [31:0] mem_data4;

    logic [31:0] imem [4];
    assign mem_data  = imem[mem_addr[3:2]];
    assign mem_data4 = imem[mem_addr4[3:2]];

    imem_arbiter #(.NUM_PORTS(2), .ADDR_WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_addr (req_addr),
        .rvalid   (rvalid),
        .rdata    (rdata),
        .mem_addr (mem_addr),
        .mem_data (mem_data)
    );

    imem_arbiter #(.NUM_PORTS(4), .ADDR_WIDTH(16)) dut4 (
        .clk      (clk),
        .rst      (rst),
        .req      (req4),
        .req_addr (req_addr4),
        .rvalid   (rvalid4),
        .rdata    (rdata4),
        .mem_addr (mem_addr4),
        .mem_data (mem_data4)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  req;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [31:0] exp_addr;
        logic [1:0]  exp_rvalid;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [14];

    int last_serv [4];
    int serv_cnt  [4];
    int port;

    initial begin
        imem[0] = 32'hdeadbeef;
        imem[1] = 32'hcafebabe;
        imem[2] = 32'h12345678;
        imem[3] = 32'h0badf00d;

        vecs[0]  = '{2'b01, 32'h0, 32'h4, 32'h0, 2'b01, 32'hdeadbeef};
        vecs[1]  = '{2'b01, 32'h0, 32'h4, 32'h0, 2'b00, 32'hdeadbeef};
        vecs[2]  = '{2'b00, 32'h0, 32'h4, 32'h0, 2'b00, 32'hdeadbeef};
        vecs[3]  = '{2'b11, 32'h0, 32'h4, 32'h4, 2'b10, 32'hcafebabe};
        vecs[4]  = '{2'b11, 32'h0, 32'h4, 32'h0, 2'b01, 32'hdeadbeef};
        vecs[5]  = '{2'b11, 32'h0, 32'h4, 32'h4, 2'b10, 32'hcafebabe};
        vecs[6]  = '{2'b11, 32'h0, 32'h4, 32'h0, 2'b01, 32'hdeadbeef};
        vecs[7]  = '{2'b00, 32'h0, 32'h4, 32'h0, 2'b00, 32'hdeadbeef};
        vecs[8]  = '{2'b10, 32'h0, 32'h8, 32'h8, 2'b10, 32'h12345678};
        vecs[9]  = '{2'b00, 32'h0, 32'h8, 32'h8, 2'b00, 32'h12345678};
        vecs[10] = '{2'b11, 32'hC, 32'h4, 32'hC, 2'b01, 32'h0badf00d};
        vecs[11] = '{2'b00, 32'hC, 32'h4, 32'hC, 2'b00, 32'h0badf00d};
        vecs[12] = '{2'b01, 32'h6, 32'h4, 32'h6, 2'b01, 32'hcafebabe};
        vecs[13] = '{2'b00, 32'h6, 32'h4, 32'h6, 2'b00, 32'hcafebabe};

        rst       = 1'b1;
        req       = '0;
        req_addr  = '0;
        req4      = '0;
        req_addr4 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rvalid",   64'(rvalid),   64'h0);
        chk("reset_rdata",    64'(rdata),    64'h0);
        chk("reset_mem_addr", 64'(mem_addr), 64'h0);
        chk("reset_rvalid4",  64'(rvalid4),  64'h0);
        rst = 1'b0;

        for (int v = 0; v < 14; v++) begin
            req      = vecs[v].req;
            req_addr = {vecs[v].a1, vecs[v].a0};
            #1;
            chk($sformatf("vec%0d_mem_addr", v), 64'(mem_addr), 64'(vecs[v].exp_addr));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_rvalid", v), 64'(rvalid), 64'(vecs[v].exp_rvalid));
            chk($sformatf("vec%0d_rdata", v),  64'(rdata),  64'(vecs[v].exp_rdata));
            $display("vec %0d: req=%b mem_addr=0x%0h rvalid=%b rdata=0x%08h",
                     v, vecs[v].req, vecs[v].exp_addr, rvalid, rdata);
        end

        // Reset lands while port 1's response is on the bus.
        req      = 2'b10;
        req_addr = {32'h4, 32'h0};
        @(posedge clk);
        #1;
        chk("rst_pre_rvalid", 64'(rvalid), 64'h2);
        rst = 1'b1;
        #1;
        chk("rst_async_rvalid",   64'(rvalid),   64'h0);
        chk("rst_async_rdata",    64'(rdata),    64'h0);
        chk("rst_async_mem_addr", 64'(mem_addr), 64'h0);
        @(posedge clk);
        #1;
        chk("rst_held_rvalid", 64'(rvalid), 64'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_release_rvalid", 64'(rvalid), 64'h2);
        chk("rst_release_rdata",  64'(rdata),  64'hcafebabe);
        $display("reset mid-response: rvalid=%b rdata=0x%08h after release", rvalid, rdata);
        req = '0;

        // Four ports all holding requests: strict rotation 0,1,2,3 from ptr=0.
        for (int i = 0; i < 4; i++) begin
            last_serv[i] = -1;
            serv_cnt[i]  = 0;
        end
        req4      = 4'b1111;
        req_addr4 = {16'hC, 16'h8, 16'h4, 16'h0};
        for (int cyc = 0; cyc < 24; cyc++) begin
            @(posedge clk);
            #1;
            chk($sformatf("rr4_onehot_c%0d", cyc), 64'($countones(rvalid4)), 64'd1);
            chk($sformatf("rr4_port_c%0d", cyc), 64'(rvalid4), 64'(4'b0001 << (cyc % 4)));
            port = 0;
            for (int i = 0; i < 4; i++) begin
                if (rvalid4[i]) port = i;
            end
            chk($sformatf("rr4_rdata_c%0d", cyc), 64'(rdata4), 64'(imem[port]));
            if (last_serv[port] >= 0) begin
                chk($sformatf("rr4_wait_ok_c%0d", cyc), 64'((cyc - last_serv[port]) <= 8), 64'd1);
            end
            last_serv[port] = cyc;
            serv_cnt[port]++;
            $display("rr4 cycle %0d: rvalid=%b rdata=0x%08h", cyc, rvalid4, rdata4);
        end
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rr4_count_p%0d", i), 64'(serv_cnt[i]), 64'd6);
        end
        req4 = '0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
